// File: rtl/jacobi_result_streamer.sv
// -----------------------------------------------------------------------------
// jacobi_result_streamer
//
// Reads a finished Jacobi decomposition out of the result memory and sends it
// as an AXI4-Stream frame. The eigenvalues (the diagonal of the
// upper-triangular A) come first. The full V matrix follows in row-major
// order.
//
// Optional feature macro: JACOBI_OUT_PACK16_EN
//   undefined : each element is sign-extended to OW bits, one element per beat
//   defined   : each element is rounded half-to-even to Q(1.4.11) and two
//               elements are packed per beat (even element in the low half)
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           frame request pulse, ignored while busy
//   busy            frame in progress
//   done            one-cycle pulse after the tlast handshake
//   mem_rd_en       result memory read strobe
//   mem_rd_addr     result memory read address
//   mem_rd_data     read data, valid one cycle after mem_rd_en
//   m_axis_*        AXI4-Stream master (tdata, tvalid, tready, tlast)
// -----------------------------------------------------------------------------
module jacobi_result_streamer #(
    parameter int N      = 8,
    parameter int ADDR_W = 7,
    parameter int DW     = 20,
    parameter int V_OFF  = 36,
    parameter int OW     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DW-1:0]     mem_rd_data,
    output logic [OW-1:0]     m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);

    localparam int E  = N + N * N;     // elements per frame
    localparam int EW = $clog2(E);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_e;

    state_e            state_q;
    logic              busy_q, done_q;
    logic [EW-1:0]     elem_q;                  // index of the next element to read
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ret_q, ret_last_q;       // read data valid on mem_rd_data this cycle
    logic [1:0]        pend_q;                  // beats started but not yet in the FIFO
    logic [1:0]        fifo_cnt_q;
    logic              wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]     fifo_data_q [2];
    logic [1:0]        fifo_last_q;

`ifdef JACOBI_OUT_PACK16_EN
    logic              ret_odd_q;               // returning element sits in the high half
    logic [15:0]       lo_q;                    // rounded even element awaiting its partner

    // Drop 4 LSBs, round half to even, wrap into 16 bits.
    function automatic logic [15:0] round_half_even(input logic [DW-1:0] x);
        logic [15:0] q;
        logic        inc;
        q   = x[DW-1:4];
        inc = x[3] & ((x[2:0] != 3'b000) | q[0]);
        return q + 16'(inc);
    endfunction
`endif

    logic          pop, push, new_beat, issue_last, issue_beat;
    logic [2:0]    committed;
    logic [OW-1:0] push_data;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        pop        = m_axis_tvalid & m_axis_tready;
        issue_last = (elem_q == EW'(E - 1));
        // FIFO slots already spoken for once this cycle's pop is taken out.
        // Counting the pop lets a read go out every cycle while draining.
        committed  = 3'(fifo_cnt_q) + 3'(pend_q) - 3'(pop);
`ifdef JACOBI_OUT_PACK16_EN
        new_beat   = ~elem_q[0];           // only an even element opens a beat
        push       = ret_q & ret_odd_q;
        push_data  = OW'({round_half_even(mem_rd_data), lo_q});
`else
        new_beat   = 1'b1;
        push       = ret_q;
        push_data  = {{(OW - DW){mem_rd_data[DW-1]}}, mem_rd_data};
`endif
        mem_rd_en  = (state_q == S_FETCH) && (!new_beat || committed < 3'd2);
        issue_beat = mem_rd_en & new_beat;

        // The diagonal walk is d(i+1) = d(i) + (N - i). After the last
        // diagonal the walk jumps to V, which is read linearly.
        addr_d = addr_q + ADDR_W'(1);
        if (elem_q < EW'(N - 1))
            addr_d = addr_q + ADDR_W'(N) - ADDR_W'(elem_q);
        else if (elem_q == EW'(N - 1))
            addr_d = ADDR_W'(V_OFF);
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            elem_q      <= '0;
            addr_q      <= '0;
            ret_q       <= 1'b0;
            ret_last_q  <= 1'b0;
            pend_q      <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_last_q <= '0;
            // NOTE: the two FIFO entries are reset because tdata must read
            // zero out of reset; larger storage arrays would not be.
            for (int i = 0; i < 2; i++) fifo_data_q[i] <= '0;
`ifdef JACOBI_OUT_PACK16_EN
            ret_odd_q   <= 1'b0;
            lo_q        <= '0;
`endif
        end else begin
            done_q     <= 1'b0;
            ret_q      <= mem_rd_en;
            ret_last_q <= mem_rd_en & issue_last;
`ifdef JACOBI_OUT_PACK16_EN
            ret_odd_q  <= elem_q[0];
            if (ret_q && !ret_odd_q) lo_q <= round_half_even(mem_rd_data);
`endif
            if (push) begin
                fifo_data_q[wr_ptr_q] <= push_data;
                fifo_last_q[wr_ptr_q] <= ret_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            fifo_cnt_q <= fifo_cnt_q + 2'(push) - 2'(pop);
            pend_q     <= pend_q + 2'(issue_beat) - 2'(push);

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FETCH;
                        busy_q  <= 1'b1;
                        elem_q  <= '0;
                        addr_q  <= '0;
                    end
                end
                S_FETCH: begin
                    if (mem_rd_en) begin
                        elem_q <= elem_q + EW'(1);
                        addr_q <= addr_d;
                        if (issue_last) state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && m_axis_tlast) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign mem_rd_addr   = addr_q;
    assign m_axis_tvalid = (fifo_cnt_q != 2'd0);
    assign m_axis_tdata  = fifo_data_q[rd_ptr_q];
    assign m_axis_tlast  = m_axis_tvalid & fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_jacobi_result_streamer.sv
// -----------------------------------------------------------------------------
// tb_jacobi_result_streamer
//
// Directed and random-stall stimulus for jacobi_result_streamer. The bench
// holds its own copy of the result memory. It works out each expected beat
// from closed-form element addresses and plain integer rounding.
// Follows JACOBI_OUT_PACK16_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_jacobi_result_streamer;

    localparam int N      = 8;
    localparam int ADDR_W = 7;
    localparam int DW     = 20;
    localparam int V_OFF  = 36;
    localparam int OW     = 32;
    localparam int E      = N + N * N;
`ifdef JACOBI_OUT_PACK16_EN
    localparam int NB     = E / 2;
`else
    localparam int NB     = E;
`endif
    localparam int ABORT_AT = NB * 5 / 9;
    localparam int BUDGET   = 1000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              busy, done, mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DW-1:0]     mem_rd_data = '0;
    logic [OW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid, m_axis_tlast;
    logic              m_axis_tready = 1'b1;

    logic [DW-1:0] mem [128];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [31:0]   got_data [$];
    logic          got_last [$];
    logic [31:0]   ref_data [$];

    jacobi_result_streamer #(
        .N(N), .ADDR_W(ADDR_W), .DW(DW), .V_OFF(V_OFF), .OW(OW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    always #5 clk = ~clk;

    // Result memory with one cycle of read latency.
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    // Address of frame element e: diagonal of row e in the packed upper
    // triangle, then V row-major.
    function automatic int exp_addr(input int e);
        if (e < N) return e * N - (e * (e - 1)) / 2;
        return V_OFF + e - N;
    endfunction

    function automatic logic [15:0] round16(input logic [DW-1:0] x);
        int s, q, r;
        s = $signed(x);
        q = s >>> 4;
        r = s - q * 16;
        if (r > 8 || (r == 8 && (q & 1) != 0)) q = q + 1;
        return q[15:0];
    endfunction

    function automatic logic [31:0] exp_beat(input int b);
        logic [DW-1:0] x;
`ifdef JACOBI_OUT_PACK16_EN
        x = mem[exp_addr(2 * b)];
        return {round16(mem[exp_addr(2 * b + 1)]), round16(x)};
`else
        x = mem[exp_addr(b)];
        return {{(32 - DW){x[DW-1]}}, x};
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Run one frame, collecting handshaken beats. Inputs change at the
    // falling edge, and outputs are sampled 1 time unit later.
    task automatic run_frame(input bit pre_started, input bit rand_rdy, input int inject_at,
                             input bit chain, input int abort_at,
                             output int first_valid, output int vcount);
        bit          seen_last, finished, injected, prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        int          abort_stage;
        got_data.delete();
        got_last.delete();
        first_valid = -1; vcount = 0; seen_last = 0; finished = 0; injected = 0;
        prev_stall = 0; prev_data = '0; prev_last = 1'b0; abort_stage = 0;
        if (!pre_started) begin
            @(negedge clk);
            start = 1'b1;
        end
        for (int c = 1; c <= BUDGET; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (abort_stage == 2) begin
                rst = 1'b0;
                #1;
                check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_rd_en", 32'(mem_rd_en), 32'd0);
                finished = 1;
                break;
            end
            if (abort_stage == 1) begin
                rst = 1'b1;
                m_axis_tready = 1'b0;
                abort_stage = 2;
                continue;
            end
            if (inject_at > 0 && !injected && got_data.size() >= inject_at) begin
                start = 1'b1;
                injected = 1;
            end
            if (seen_last && chain) start = 1'b1;
            m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (c == 1) begin
                check("c1_busy", 32'(busy), 32'd1);
                check("c1_rd_en", 32'(mem_rd_en), 32'd1);
                check("c1_addr", 32'(mem_rd_addr), 32'd0);
            end
            if (seen_last) begin
                check("done_pulse", 32'(done), 32'd1);
                check("busy_fall", 32'(busy), 32'd0);
                finished = 1;
                break;
            end
            check("done_low", 32'(done), 32'd0);
            if (prev_stall) begin
                check("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
                check("stall_tdata", m_axis_tdata, prev_data);
                check("stall_tlast", 32'(m_axis_tlast), 32'(prev_last));
            end
            if (m_axis_tvalid) begin
                if (first_valid < 0) first_valid = c;
                vcount++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got_data.push_back(m_axis_tdata);
                got_last.push_back(m_axis_tlast);
                if (m_axis_tlast) seen_last = 1;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (abort_at > 0 && got_data.size() == abort_at) abort_stage = 1;
        end
        check("frame_terminated", 32'(finished), 32'd1);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_beats"}, 32'(got_data.size()), 32'(NB));
        for (int i = 0; i < got_data.size() && i < NB; i++) begin
            check($sformatf("%s_data%0d", tag, i), got_data[i], exp_beat(i));
            check($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(i == NB - 1));
        end
    endtask

    initial begin
        int          fv, vc;
        logic [19:0] lfsr;

        for (int a = 0; a < 128; a++) mem[a] = 20'(a);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_rd_en", 32'(mem_rd_en), 32'd0);
        check("reset_rd_addr", 32'(mem_rd_addr), 32'd0);
        check("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("reset_tlast", 32'(m_axis_tlast), 32'd0);
        check("reset_tdata", m_axis_tdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Ramp memory (data[a] = a) with tready held high.
        run_frame(1'b0, 1'b0, 0, 1'b0, 0, fv, vc);
`ifdef JACOBI_OUT_PACK16_EN
        check("first_valid_cycle", 32'(fv), 32'd4);
`else
        check("first_valid_cycle", 32'(fv), 32'd3);
        check("valid_cycles", 32'(vc), 32'(NB));
`endif
        check_frame("ramp");

        // Sign extension or rounding corner values in the first two elements.
`ifdef JACOBI_OUT_PACK16_EN
        mem[0] = 20'h00018;
        mem[8] = 20'h00028;
        run_frame(1'b0, 1'b0, 0, 1'b0, 0, fv, vc);
        check("pack_beat1", got_data[0], 32'h00020002);
`else
        mem[0] = 20'hFFFFF;
        mem[8] = 20'h7FFFF;
        run_frame(1'b0, 1'b0, 0, 1'b0, 0, fv, vc);
        check("sext_beat1", got_data[0], 32'hFFFFFFFF);
        check("sext_beat2", got_data[1], 32'h0007FFFF);
`endif
        check_frame("corner");

        // Pseudo-random memory, first with free flow and then with random stalls.
        lfsr = 20'h5A5A5 ^ 20'($urandom);
        if (lfsr == 20'd0) lfsr = 20'd1;
        for (int a = 0; a < 128; a++) begin
            lfsr   = {lfsr[18:0], lfsr[19] ^ lfsr[16]};
            mem[a] = lfsr;
        end
        run_frame(1'b0, 1'b0, 0, 1'b0, 0, fv, vc);
        check_frame("lfsr_free");
        ref_data = got_data;
        run_frame(1'b0, 1'b1, 0, 1'b0, 0, fv, vc);
        check_frame("lfsr_stall");
        check("stall_vs_free_len", 32'(got_data.size()), 32'(ref_data.size()));
        for (int i = 0; i < got_data.size() && i < ref_data.size(); i++)
            check($sformatf("stall_vs_free%0d", i), got_data[i], ref_data[i]);

        // Reset in the middle of a frame, then a clean frame.
        run_frame(1'b0, 1'b0, 0, 1'b0, ABORT_AT, fv, vc);
        run_frame(1'b0, 1'b0, 0, 1'b0, 0, fv, vc);
        check_frame("after_rst");

        // A start while busy is ignored. A start in the done cycle chains frames.
        run_frame(1'b0, 1'b0, 5, 1'b1, 0, fv, vc);
        check_frame("chain_a");
        run_frame(1'b1, 1'b0, 0, 1'b0, 0, fv, vc);
        check_frame("chain_b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jacobi_result_streamer.md
# jacobi_result_streamer

Drains a completed Jacobi decomposition from the result memory and transmits it as an AXI4-Stream of `AXI4_FIFO_WORD_WIDTH`-bit words. It is the output-side counterpart of the input loader, which accepts `JACOBI_N_INPUT_DATA` words into the same memory. The frame order is eigenvalues first (diagonal of A), then the full eigenvector matrix V in row-major order. The block sits between the Jacobi core's result memory read port and the AXI4 output FIFO.

## Interface
Reset is synchronous and active-high; there is one clock.

Parameters (defaults taken from package `common`):
- `N`, `JACOBI_N` = 8: matrix size.
- `ADDR_W`, `JACOBI_ADDR_WIDTH` = 7: memory address width.
- `DW`, `JACOBI_OUTPUT_WORD_WIDTH` = 20: stored word, Q(1.4.15).
- `V_OFF`, `JACOBI_V_OFFSET` = 36: base address of V.
- `OW`, `AXI4_FIFO_WORD_WIDTH` = 32: stream word width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `start` in 1: one-cycle pulse that begins a frame; ignored while `busy`.
- `busy` out 1: high from the cycle after an accepted `start` until the last beat is accepted.
- `done` out 1: one-cycle pulse in the cycle after the `tlast` beat is accepted.
- `mem_rd_en` out 1: memory read strobe.
- `mem_rd_addr` out ADDR_W: read address.
- `mem_rd_data` in DW: read data, valid exactly 1 cycle after `mem_rd_en`.
- `m_axis_tdata` out OW: stream data.
- `m_axis_tvalid` out 1: stream valid.
- `m_axis_tready` in 1: stream ready.
- `m_axis_tlast` out 1: marks the last beat of the frame.

## Operation
Memory layout:
- A is stored as an upper triangle, row-major, at addresses 0..35.
- The diagonal address of row i is d(i), with d(0)=0 and d(i+1)=d(i)+(N−i). This gives 0, 8, 15, 21, 26, 30, 33, 35, generated incrementally with no multiplier.
- V occupies V_OFF..V_OFF+N*N−1 (36..99).

Element sequence:
- 8 eigenvalues, at d(0)..d(7).
- Then the 64 V entries, at addresses 36..99 ascending.
- Total E = 72 elements.

State machine:
- IDLE: waits for `start`.
- FETCH: issues reads and fills the output buffer.
- DRAIN: all reads have been issued; waits for the buffer to empty.
- Back to IDLE, pulsing `done`.

Flow control:
- A read is issued only if (buffer occupancy + reads in flight) < 2.
- The returning data is written into a 2-entry output FIFO.
- `m_axis_tvalid` equals FIFO not-empty.
- Data is never dropped or duplicated under any `tready` pattern.

Word formatting (default):
- Each element is sign-extended from DW to OW bits. One element per beat, 72 beats.
- `tlast` is set on beat 72 only.

Boundary conditions:
- `start` while `busy` is ignored and has no effect on the frame.
- `start` in the same cycle as `done` is accepted, and a new frame begins.
- `rst` at any time returns the block to IDLE, flushes the FIFO and in-flight reads, and clears the counters. Outputs follow the reset values from the next edge.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_rd_en`=0, `mem_rd_addr`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0.
- `start` sampled at edge 0 gives `busy`=1 and the first `mem_rd_en` in cycle 1 (addr 0). Data returns in cycle 2. `tvalid` is high in cycle 3.
- Throughput: 1 beat/cycle sustained while `tready`=1. With `tready` held high, the default-mode frame is 72 consecutive valid cycles.
- AXI rules:
  - `tdata` and `tlast` are stable while `tvalid`=1 and `tready`=0.
  - `tvalid` never drops without a handshake.
  - `tvalid` does not depend combinationally on `tready`.
- `done` is asserted in the cycle after the `tlast` handshake. `busy` falls in that same cycle.

## Configuration
- `JACOBI_OUT_PACK16_EN` defined:
  - Each element is rounded from Q(1.4.15) to 16-bit Q(1.4.11) by dropping 4 LSBs with round-half-to-even, the same rule as the package `fxp_round` with N=4.
  - The result wraps; no saturation is applied.
  - Element 2k goes in `tdata[15:0]` and element 2k+1 in `tdata[31:16]`.
  - The frame has 36 beats, with `tlast` on beat 36.
  - One beat requires two reads. Sustained throughput is 1 beat / 2 cycles.
- Macro undefined: the default sign-extend mode described above, 72 beats.

## Test plan
- Memory preloaded with data[a]=a; `tready`=1; pulse `start` → beats carry 0, 8, 15, 21, 26, 30, 33, 35, 36, 37, …, 99. `tlast` is set only on beat 72. `done` arrives 1 cycle after beat 72.
- mem[0]=20'hFFFFF (−1 LSB) → beat 1 `tdata`=32'hFFFFFFFF. mem[8]=20'h7FFFF → beat 2 `tdata`=32'h0007FFFF.
- Random `tready` (50%) with LFSR memory contents → the beat sequence is identical to the `tready`=1 run, and `tdata`/`tlast` are stable during stalls.
- `rst` asserted at beat 40 with `tready` low → next cycle `tvalid`=0 and `busy`=0. A fresh `start` then streams the full 72 beats starting at address 0.
- `start` pulses at beats 5 and 72 (the `done` cycle) → the first pulse is ignored. The second is accepted, and back-to-back frames are produced.
- PACK16: mem[0]=20'h00018 and mem[8]=20'h00028 → beat 1 `tdata`=32'h00020002; the 0x18 rounds to 2 and the 0x28 rounds half-even to 2. The frame has 36 beats, with `tlast` on beat 36.
